// File: rtl/ex_mem_pkg.sv
// Shared definitions for the execute/memory stage: data width, ALU op-code
// type and op-code values.
package ex_mem_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [4:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 5'd0;
    localparam alu_op_t ALU_SUB  = 5'd1;
    localparam alu_op_t ALU_SLL  = 5'd2;
    localparam alu_op_t ALU_SLT  = 5'd3;
    localparam alu_op_t ALU_SLTU = 5'd4;
    localparam alu_op_t ALU_XOR  = 5'd5;
    localparam alu_op_t ALU_SRL  = 5'd6;
    localparam alu_op_t ALU_SRA  = 5'd7;
    localparam alu_op_t ALU_OR   = 5'd8;
    localparam alu_op_t ALU_AND  = 5'd9;
    localparam alu_op_t ALU_PASSB = 5'd10;
    localparam alu_op_t ALU_ADDJ = 5'd11;

endpackage

// File: rtl/ex_mem_alu.sv
// Combinational 32-bit RV32I ALU. Unknown op codes produce zero.
module ex_mem_alu
    import ex_mem_pkg::*;
(
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;

    // Select the result for the requested operation; shifts use b[4:0] only
    always_comb begin
        shamt  = b[4:0];
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << shamt;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_PASSB: result = b;
            ALU_ADDJ:  result = (a + b) & {{(XLEN-1){1'b1}}, 1'b0};
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// Combined execute/memory stage: branch comparator, operand muxes + ALU,
// and a word-addressed data memory addressed by the ALU result.
// Optional macro BRANCH_UNSIGNED_EN adds input BrUn selecting an unsigned BrLt.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned VERIFY_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ALUop_i,
    input  logic [XLEN-1:0] DataOutReg1,
    input  logic [XLEN-1:0] DataOutReg2,
    input  logic            ALUSrc1,
    input  logic            ALUSrc2,
    input  logic [XLEN-1:0] Imm,
    input  logic [XLEN-1:0] PC,
    input  logic            MemWE,
`ifdef BRANCH_UNSIGNED_EN
    input  logic            BrUn,
`endif
    output logic            BrEq,
    output logic            BrLt,
    output logic [4:0]      ALUop_o,
    output logic [XLEN-1:0] ALUOut,
    output logic [XLEN-1:0] MemDataOut,
    output logic [XLEN-1:0] verify
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] VIDX = AW'(VERIFY_ADDR);

    logic [XLEN-1:0] mem [DEPTH];
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic [AW-1:0]   idx;
    logic            eq;
    logic            lt;

    // Operand selection and word index (byte offset and upper bits dropped)
    always_comb begin
        op_a = ALUSrc1 ? PC  : DataOutReg1;
        op_b = ALUSrc2 ? Imm : DataOutReg2;
        idx  = alu_result[AW+1:2];
    end

    ex_mem_alu u_alu (
        .op     (ALUop_i),
        .a      (op_a),
        .b      (op_b),
        .result (alu_result)
    );

    // Branch comparator on raw register values
    always_comb begin
        eq = (DataOutReg1 == DataOutReg2);
`ifdef BRANCH_UNSIGNED_EN
        lt = BrUn ? (DataOutReg1 < DataOutReg2)
                  : ($signed(DataOutReg1) < $signed(DataOutReg2));
`else
        lt = ($signed(DataOutReg1) < $signed(DataOutReg2));
`endif
    end

    // Data memory: cleared while rst is high, otherwise written on the edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (MemWE) begin
            mem[idx] <= DataOutReg2;
        end
    end

    // Output drive; reset forces every output to zero regardless of the clock
    always_comb begin
        if (rst) begin
            BrEq       = 1'b0;
            BrLt       = 1'b0;
            ALUop_o    = '0;
            ALUOut     = '0;
            MemDataOut = '0;
            verify     = '0;
        end else begin
            BrEq       = eq;
            BrLt       = lt;
            ALUop_o    = ALUop_i;
            ALUOut     = alu_result;
            MemDataOut = mem[idx];
            verify     = mem[VIDX];
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed literal checks plus a
// randomized run compared every cycle against a behavioural model.
module tb_ex_mem_stage;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned VADDR = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ALUop_i = '0;
    logic [31:0] DataOutReg1 = '0;
    logic [31:0] DataOutReg2 = '0;
    logic        ALUSrc1 = 1'b0;
    logic        ALUSrc2 = 1'b0;
    logic [31:0] Imm = '0;
    logic [31:0] PC = '0;
    logic        MemWE = 1'b0;
`ifdef BRANCH_UNSIGNED_EN
    logic        BrUn = 1'b0;
`endif
    logic        BrEq;
    logic        BrLt;
    logic [4:0]  ALUop_o;
    logic [31:0] ALUOut;
    logic [31:0] MemDataOut;
    logic [31:0] verify;

    logic [31:0] mdl_mem [DEPTH];
    int          nchecks = 0;
    int          nerrors = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.DEPTH(DEPTH), .VERIFY_ADDR(VADDR)) dut (
        .clk         (clk),
        .rst         (rst),
        .ALUop_i     (ALUop_i),
        .DataOutReg1 (DataOutReg1),
        .DataOutReg2 (DataOutReg2),
        .ALUSrc1     (ALUSrc1),
        .ALUSrc2     (ALUSrc2),
        .Imm         (Imm),
        .PC          (PC),
        .MemWE       (MemWE),
`ifdef BRANCH_UNSIGNED_EN
        .BrUn        (BrUn),
`endif
        .BrEq        (BrEq),
        .BrLt        (BrLt),
        .ALUop_o     (ALUop_o),
        .ALUOut      (ALUOut),
        .MemDataOut  (MemDataOut),
        .verify      (verify)
    );

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a << sh;
            3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4:  return (a < b) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return a >> sh;
            7:  return $unsigned($signed(a) >>> sh);
            8:  return a | b;
            9:  return a & b;
            10: return b;
            11: return (a + b) & 32'hFFFF_FFFE;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] cur_alu();
        return ref_alu(int'(ALUop_i), ALUSrc1 ? PC : DataOutReg1, ALUSrc2 ? Imm : DataOutReg2);
    endfunction

    function automatic int word_of(input logic [31:0] byte_addr);
        return int'((byte_addr / 4) % DEPTH);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Full model comparison of every output for the current inputs
    task automatic compare_all();
        logic [31:0] e_alu;
        logic        e_lt;
        e_alu = cur_alu();
        e_lt  = $signed(DataOutReg1) < $signed(DataOutReg2);
`ifdef BRANCH_UNSIGNED_EN
        if (BrUn) e_lt = DataOutReg1 < DataOutReg2;
`endif
        if (rst) begin
            check("m_rst_breq", {31'd0, BrEq}, 32'd0);
            check("m_rst_brlt", {31'd0, BrLt}, 32'd0);
            check("m_rst_op", {27'd0, ALUop_o}, 32'd0);
            check("m_rst_alu", ALUOut, 32'd0);
            check("m_rst_mem", MemDataOut, 32'd0);
            check("m_rst_verify", verify, 32'd0);
        end else begin
            check("m_breq", {31'd0, BrEq}, {31'd0, DataOutReg1 == DataOutReg2});
            check("m_brlt", {31'd0, BrLt}, {31'd0, e_lt});
            check("m_op", {27'd0, ALUop_o}, {27'd0, ALUop_i});
            check("m_alu", ALUOut, e_alu);
            check("m_mem", MemDataOut, mdl_mem[word_of(e_alu)]);
            check("m_verify", verify, mdl_mem[VADDR]);
        end
    endtask

    // Compare at the falling edge, then apply the edge's effect to the model
    task automatic run_cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        end else if (MemWE) begin
            mdl_mem[word_of(cur_alu())] = DataOutReg2;
        end
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic s1, input logic s2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic we);
        ALUop_i = op; DataOutReg1 = r1; DataOutReg2 = r2;
        ALUSrc1 = s1; ALUSrc2 = s2; Imm = imm; PC = pc; MemWE = we;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;

        // Reset with a pending store to byte 8: outputs held at zero
        drive(5'd0, 32'd8, 32'hAAAA_5555, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
        #1;
        check("rst_alu", ALUOut, 32'd0);
        check("rst_mem", MemDataOut, 32'd0);
        check("rst_verify", verify, 32'd0);
        check("rst_op", {27'd0, ALUop_o}, 32'd0);
        check("rst_br", {30'd0, BrEq, BrLt}, 32'd0);
        run_cycle();
        run_cycle();
        rst = 1'b0;
        MemWE = 1'b0;
        #1;
        check("rst_nowrite", MemDataOut, 32'd0);
        check("rst_alu_rel", ALUOut, 32'd8);
        run_cycle();

        // ALU literal cases
        drive(5'd0, 32'd5, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd0, 1'b0);
        #1; check("add_imm", ALUOut, 32'd2); run_cycle();
        drive(5'd1, 32'd3, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1; check("sub", ALUOut, 32'hFFFF_FFFE); run_cycle();
        drive(5'd7, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 32'd4, 32'd0, 1'b0);
        #1; check("sra", ALUOut, 32'hF800_0000); run_cycle();
        drive(5'd4, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1; check("sltu", ALUOut, 32'd0);
        check("br_neg_eq", {31'd0, BrEq}, 32'd0);
        check("br_neg_lt", {31'd0, BrLt}, 32'd1);
`ifdef BRANCH_UNSIGNED_EN
        BrUn = 1'b1; #1;
        check("br_unsigned_lt", {31'd0, BrLt}, 32'd0);
        BrUn = 1'b0;
`endif
        run_cycle();
        drive(5'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1; check("slt", ALUOut, 32'd1); run_cycle();
        drive(5'd11, 32'd0, 32'd0, 1'b1, 1'b1, 32'd7, 32'd100, 1'b0);
        #1; check("addj", ALUOut, 32'd106); run_cycle();
        drive(5'd0, 32'd42, 32'd42, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1; check("br_eq", {30'd0, BrEq, BrLt}, 32'd2); run_cycle();
        drive(5'd31, 32'd77, 32'd99, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1; check("undef_alu", ALUOut, 32'd0);
        check("undef_op", {27'd0, ALUop_o}, 32'd31); run_cycle();

        // Store/load, offset-in-word and wraparound
        drive(5'd0, 32'd12, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
        #1; check("rdw_old", MemDataOut, 32'd0); run_cycle();
        MemWE = 1'b0; #1;
        check("load", MemDataOut, 32'hDEAD_BEEF); run_cycle();
        DataOutReg1 = 32'd13; #1;
        check("load_unaligned", MemDataOut, 32'hDEAD_BEEF); run_cycle();
        DataOutReg1 = 32'd12 + 4 * DEPTH; #1;
        check("load_wrap", MemDataOut, 32'hDEAD_BEEF); run_cycle();

        // Verify port
        drive(5'd0, 4 * VADDR, 32'h1234, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
        run_cycle();
        check("verify_write", verify, 32'h1234);
        drive(5'd0, 32'd36, 32'h5555, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
        run_cycle();
        check("verify_other", verify, 32'h1234);

        // Reset raised mid-cycle aborts the pending store to byte 24
        drive(5'd0, 32'd24, 32'hCAFE_F00D, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
        #2; rst = 1'b1; #1;
        check("abort_alu", ALUOut, 32'd0);
        check("abort_verify", verify, 32'd0);
        run_cycle();
        rst = 1'b0; MemWE = 1'b0; #1;
        check("abort_nowrite", MemDataOut, 32'd0);
        check("abort_cleared", verify, 32'd0);
        run_cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] r1, r2, im;
            r1 = $urandom();
            r2 = $urandom();
            im = $urandom();
            if ($urandom_range(0, 2) == 0) r1 = $urandom_range(0, 4 * DEPTH + 8);
            if ($urandom_range(0, 3) == 0) r2 = r1;
            if ($urandom_range(0, 2) == 0) im = $urandom_range(0, 40);
            drive(($urandom_range(0, 9) == 0) ? 5'($urandom_range(12, 31)) : 5'($urandom_range(0, 11)),
                  r1, r2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  im, $urandom(), ($urandom_range(0, 2) == 0));
`ifdef BRANCH_UNSIGNED_EN
            BrUn = 1'($urandom_range(0, 1));
`endif
            rst = ($urandom_range(0, 59) == 0);
            run_cycle();
        end
        rst = 1'b0;
        MemWE = 1'b0;
        run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
